// File: rtl/mul8_quad_sequencer.sv
// mul8_quad_sequencer: sequential 8x8 unsigned multiplier that reuses one
// 4x4 partial-product unit across the four nibble quadrants (LL, HL, LH, HH)
// and accumulates the shifted partial products into a 16-bit result.
// The LL quadrant can optionally use a low-power approximate 4x4 unit:
// the low four product columns are OR-ed (no carries generated or
// propagated), and the upper columns (weights 16..64) are summed exactly.
// For example, 15*15 gives 0xBF instead of 0xE1.
module mul8_quad_sequencer #(
  parameter int unsigned USE_APPROX = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        approx_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q0,
    S_Q1,
    S_Q2,
    S_Q3,
    S_DONE
  } state_t;

  localparam logic LP_APX_AVAIL = (USE_APPROX != 0);

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_apx;
  logic [15:0] r_acc;
  logic        r_out_valid;
  logic [15:0] r_y;
  logic        r_busy;

  logic [3:0]  w_opa;
  logic [3:0]  w_opb;
  logic [7:0]  w_pp_exact;
  logic [7:0]  w_pp_apx;
  logic [7:0]  w_pp;
  logic [15:0] w_addend;
  logic [15:0] w_acc_next;
  logic        w_accept;

  // Operand mux: select nibbles of the latched operands for the current quadrant
  always_comb begin
    w_opa = r_a[3:0];
    w_opb = r_b[3:0];
    case (r_state)
      S_Q1: begin
        w_opa = r_a[7:4];
        w_opb = r_b[3:0];
      end
      S_Q2: begin
        w_opa = r_a[3:0];
        w_opb = r_b[7:4];
      end
      S_Q3: begin
        w_opa = r_a[7:4];
        w_opb = r_b[7:4];
      end
      default: begin
        w_opa = r_a[3:0];
        w_opb = r_b[3:0];
      end
    endcase
  end

  // Shared exact 4x4 partial-product unit
  always_comb begin
    w_pp_exact = {4'b0000, w_opa} * {4'b0000, w_opb};
  end

  generate
    if (USE_APPROX != 0) begin : g_apx
      logic [3:0] w_apx_lo;
      logic [7:0] w_apx_hi;

      // Approximate 4x4: OR the low four columns, add the upper columns exactly
      always_comb begin
        w_apx_lo = '0;
        w_apx_hi = '0;
        for (int unsigned i = 0; i < 4; i++) begin
          for (int unsigned j = 0; j < 4; j++) begin
            if ((i + j) < 4) begin
              w_apx_lo[i + j] = w_apx_lo[i + j] | (w_opa[i] & w_opb[j]);
            end else if (w_opa[i] & w_opb[j]) begin
              w_apx_hi = w_apx_hi + (8'd1 << (i + j));
            end
          end
        end
        w_pp_apx = w_apx_hi | {4'b0000, w_apx_lo};
      end
    end else begin : g_no_apx
      // Approximate unit not built; the latched approx flag is always 0
      always_comb begin
        w_pp_apx = '0;
      end
    end
  endgenerate

  // Partial-product select, shift into position and accumulate
  always_comb begin
    w_pp = ((r_state == S_Q0) && r_apx) ? w_pp_apx : w_pp_exact;
    case (r_state)
      S_Q0:       w_addend = {8'h00, w_pp};
      S_Q1, S_Q2: w_addend = {4'h0, w_pp, 4'h0};
      S_Q3:       w_addend = {w_pp, 8'h00};
      default:    w_addend = '0;
    endcase
    w_acc_next = r_acc + w_addend;
  end

  // Handshake qualifiers; in_ready depends only on state and out_ready
  always_comb begin
    in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    w_accept = in_valid & in_ready;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_apx       <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_apx   <= approx_en & LP_APX_AVAIL;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_Q0;
          end
        end
        S_Q0: begin
          r_acc   <= w_acc_next;
          r_state <= S_Q1;
        end
        S_Q1: begin
          r_acc   <= w_acc_next;
          r_state <= S_Q2;
        end
        S_Q2: begin
          r_acc   <= w_acc_next;
          r_state <= S_Q3;
        end
        S_Q3: begin
          r_acc       <= w_acc_next;
          r_y         <= w_acc_next;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // Output handshake and a new accept may share the same edge
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_a     <= a;
              r_b     <= b;
              r_apx   <= approx_en & LP_APX_AVAIL;
              r_acc   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_Q0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Drive ports from registers
  always_comb begin
    out_valid = r_out_valid;
    y         = r_y;
    busy      = r_busy;
  end

endmodule

// File: tb/tb_mul8_quad_sequencer.sv
// Scoreboard bench for mul8_quad_sequencer. Two instances share all inputs:
// index 0 has the approximate LL unit, index 1 is built without it.
module tb_mul8_quad_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        approx_en;
  logic        out_ready;
  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic [15:0] y_w         [2];
  logic        busy_w      [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int y_apx;
    int y_exact;
    int acc;
  } exp_t;

  exp_t sbq[$];
  int   hs_log[$];
  int   acc_log[$];
  bit   rnd_or = 0;
  int   prev_y    [2];
  bit   prev_hold [2];

  mul8_quad_sequencer #(.USE_APPROX(1)) u_dut_apx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .y(y_w[0]), .busy(busy_w[0])
  );

  mul8_quad_sequencer #(.USE_APPROX(0)) u_dut_ex (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .y(y_w[1]), .busy(busy_w[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full product from four quadrant products with plain arithmetic.
  // The approximate LL value counts partial-product bits per column: any bit
  // in columns 0..3 sets that column's bit, columns 4..6 are summed exactly.
  function automatic int approx_ll(input int x, input int z);
    int cnt [7];
    int r;
    for (int c = 0; c < 7; c++) cnt[c] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (((x >> i) & 1) == 1 && ((z >> j) & 1) == 1) cnt[i + j]++;
    r = 0;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) r += (cnt[c] > 0) ? (1 << c) : 0;
      else       r += cnt[c] * (1 << c);
    end
    return r;
  endfunction

  function automatic int ref_mul(input int x, input int z, input bit apx);
    int al, ah, bl, bh, ll;
    al = x % 16; ah = x / 16; bl = z % 16; bh = z / 16;
    ll = apx ? approx_ll(al, bl) : al * bl;
    return (ll + (ah * bl + al * bh) * 16 + ah * bh * 256) % 65536;
  endfunction

  // Monitor: checks flow-control outputs against the scoreboard timing and
  // pops the expected product at each output handshake.
  always @(negedge clk) begin
    bit exp_busy, exp_ov, exp_ir;
    if (rst) begin
      sbq.delete();
      prev_hold[0] = 0;
      prev_hold[1] = 0;
    end else begin
      exp_busy = (sbq.size() > 0) && (cyc < sbq[0].acc + 5);
      exp_ov   = (sbq.size() > 0) && (cyc >= sbq[0].acc + 5);
      exp_ir   = (sbq.size() == 0) || (exp_ov && out_ready);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy[%0d]", k), int'(busy_w[k]), int'(exp_busy));
        chk($sformatf("out_valid[%0d]", k), int'(out_valid_w[k]), int'(exp_ov));
        chk($sformatf("in_ready[%0d]", k), int'(in_ready_w[k]), int'(exp_ir));
        if (prev_hold[k]) chk($sformatf("y_hold[%0d]", k), int'(y_w[k]), prev_y[k]);
        if (exp_ov && out_ready)
          chk($sformatf("y[%0d]", k), int'(y_w[k]), (k == 0) ? sbq[0].y_apx : sbq[0].y_exact);
        prev_hold[k] = out_valid_w[k] && !out_ready;
        prev_y[k]    = int'(y_w[k]);
      end
      if (exp_ov && out_ready) begin
        void'(sbq.pop_front());
        hs_log.push_back(cyc);
      end
      if (in_valid && exp_ir) begin
        sbq.push_back('{ref_mul(a, b, approx_en), ref_mul(a, b, 1'b0), cyc});
        acc_log.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tap, input bit scr);
    bit got;
    a = ta; b = tb_v; approx_en = tap; in_valid = 1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (in_ready_w[0] && !rst) got = 1;
      tick();
    end
    if (!got) chk("accept_timeout", 0, 1);
    in_valid = 0;
    if (scr) begin
      for (int i = 0; i < 4; i++) begin
        a = 8'($urandom); b = 8'($urandom); approx_en = 1'($urandom);
        tick();
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_out_valid[%0d]", tag, k), int'(out_valid_w[k]), 0);
      chk($sformatf("%s_y[%0d]", tag, k), int'(y_w[k]), 0);
      chk($sformatf("%s_busy[%0d]", tag, k), int'(busy_w[k]), 0);
      chk($sformatf("%s_in_ready[%0d]", tag, k), int'(in_ready_w[k]), 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst = 1; in_valid = 0; a = 0; b = 0; approx_en = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_reset_state("reset");
    tick();

    // Exact and approximate corners
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0); drain();
    chk("lat_ffxff", hs_log[hs_log.size() - 1] - acc_log[acc_log.size() - 1], 5);
    do_op(8'h00, 8'hA5, 1'b0, 1'b0); drain();
    do_op(8'h12, 8'h34, 1'b0, 1'b0); drain();
    do_op(8'h0F, 8'h0F, 1'b1, 1'b0); drain();
    do_op(8'h0F, 8'h0F, 1'b0, 1'b0); drain();
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0); drain();

    // Backpressure with a pending request
    out_ready = 0;
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid_w[0]) got = 1; else tick();
    end
    if (!got) chk("bp_wait_timeout", 0, 1);
    tick();
    a = 8'h0F; b = 8'h0F; approx_en = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_y", int'(y_w[0]), 16'hFE01);
      chk("bp_out_valid", int'(out_valid_w[0]), 1);
      chk("bp_in_ready", int'(in_ready_w[0]), 0);
      tick();
    end
    out_ready = 1;
    @(negedge clk);
    tick();
    in_valid = 0;
    drain();

    // Back-to-back with continuous in_valid/out_ready
    hs_log.delete(); acc_log.delete();
    do_op(8'h12, 8'h34, 1'b0, 1'b0);
    do_op(8'h0F, 8'h0F, 1'b0, 1'b0);
    drain();
    if (hs_log.size() == 2 && acc_log.size() == 2) begin
      chk("b2b_spacing", hs_log[1] - hs_log[0], 5);
      chk("b2b_accept_on_handshake", acc_log[1], hs_log[0]);
    end else begin
      chk("b2b_event_count", hs_log.size() * 10 + acc_log.size(), 22);
    end

    // Reset out of Q2
    do_op(8'hAB, 8'hCD, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check_reset_state("rst_q2");
    for (int i = 0; i < 10; i++) tick();

    // Operand isolation
    do_op(8'hC3, 8'h5A, 1'b1, 1'b1); drain();
    do_op(8'h0F, 8'hF0, 1'b0, 1'b1); drain();

    // Randomized traffic with random consumer stalls
    rnd_or = 1;
    for (int n = 0; n < 60; n++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    rnd_or = 0;
    out_ready = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
